// File: rtl/lcd_bus_writer.sv
// -----------------------------------------------------------------------------
// lcd_bus_writer
//
// HD44780-style character-LCD write engine. Takes one byte plus register
// select per request from the init/text sequencer and drives the LCD pins
// with programmable setup / enable-high / hold timing, followed by an
// execution wait (long wait for clear/home commands 0x01-0x03).
//
// Handshake: i_cs is a single-cycle-or-held request that is sampled only while
// the engine is IDLE (o_busy low). o_busy acts as "not ready": any i_cs seen
// while o_busy is high is dropped, nothing is queued. o_done pulses for one
// cycle on the final busy cycle; o_busy falls on the following cycle.
//
// Optional feature (macro LCD_WRITER_BUSYPOLL_EN): the fixed execution wait is
// replaced by busy-flag polling (RW=1, pads released) with a timeout of
// P_CNT_EXEC_LONG cycles. Without the macro i_lcd_data is ignored, RW is
// always 0 and the pad output enable is always 1.
//
// Parameters:
//   P_BUS_WIDTH      LCD data bus width, 4 or 8
//   P_CNT_SETUP      cycles RS/RW/data are stable before E rises
//   P_CNT_E_HIGH     cycles E is high per pulse
//   P_CNT_HOLD       cycles RS/RW/data are held after E falls
//   P_CNT_EXEC       execution wait after a normal write
//   P_CNT_EXEC_LONG  execution wait after clear/home, and busy-poll timeout
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_cs         write request
//   i_RS         register select of the request (0 command, 1 data)
//   i_data       byte to write
//   i_lcd_data   LCD data pin read-back (busy polling only)
//   o_busy       engine not IDLE
//   o_done       one-cycle completion pulse
//   o_r_RW       LCD RW pin
//   o_r_RS       LCD RS pin
//   o_r_E        LCD E pin
//   o_r_data     LCD data pins
//   o_r_data_oe  pad output enable for o_r_data
//   o_dbg_state  current FSM state (debug)
// -----------------------------------------------------------------------------
module lcd_bus_writer #(
  parameter int P_BUS_WIDTH     = 8,
  parameter int P_CNT_SETUP     = 4,
  parameter int P_CNT_E_HIGH    = 32,
  parameter int P_CNT_HOLD      = 4,
  parameter int P_CNT_EXEC      = 12_500,
  parameter int P_CNT_EXEC_LONG = 250_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cs,
  input  logic                   i_RS,
  input  logic [7:0]             i_data,
  input  logic [P_BUS_WIDTH-1:0] i_lcd_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_r_RW,
  output logic                   o_r_RS,
  output logic                   o_r_E,
  output logic [P_BUS_WIDTH-1:0] o_r_data,
  output logic                   o_r_data_oe,
  output logic [2:0]             o_dbg_state
);

  if (P_BUS_WIDTH != 4 && P_BUS_WIDTH != 8) begin : g_bad_width
    $error("lcd_bus_writer: P_BUS_WIDTH must be 4 or 8");
  end

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_E_HIGH   = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_P_SETUP  = 3'd5;
  localparam logic [2:0] S_P_E_HIGH = 3'd6;
  localparam logic [2:0] S_P_HOLD   = 3'd7;

  // Last counter value of each phase: a phase of N cycles counts 0..N-1.
  localparam logic [23:0] L_SETUP = 24'(P_CNT_SETUP - 1);
  localparam logic [23:0] L_E     = 24'(P_CNT_E_HIGH - 1);
  localparam logic [23:0] L_HOLD  = 24'(P_CNT_HOLD - 1);
  localparam logic [23:0] L_X     = 24'(P_CNT_EXEC - 1);
  localparam logic [23:0] L_XL    = 24'(P_CNT_EXEC_LONG - 1);

  logic [2:0]             state;
  logic [23:0]            cnt;
  logic [7:0]             byte_q;
  logic                   second_q;   // second (low-nibble) pulse in progress
  logic [23:0]            phase_last;
  logic                   phase_end;
  logic                   last_pulse;
  logic                   exec_long;
  logic [P_BUS_WIDTH-1:0] hi_part;
  logic [P_BUS_WIDTH-1:0] lo_part;

  if (P_BUS_WIDTH == 8) begin : g_w8
    assign hi_part = i_data;
    assign lo_part = byte_q;
  end else begin : g_w4
    assign hi_part = i_data[7:4];
    assign lo_part = byte_q[3:0];
  end

  // Clear display / return home need the long execution time.
  assign exec_long  = !o_r_RS && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);
  assign last_pulse = (P_BUS_WIDTH == 8) || second_q;

  always_comb begin
    phase_last = '0;
    case (state)
      S_SETUP, S_P_SETUP:   phase_last = L_SETUP;
      S_E_HIGH, S_P_E_HIGH: phase_last = L_E;
      S_HOLD, S_P_HOLD:     phase_last = L_HOLD;
      S_EXEC:               phase_last = exec_long ? L_XL : L_X;
      default:              phase_last = '0;
    endcase
  end

  assign phase_end   = (cnt == phase_last);
  assign o_busy      = (state != S_IDLE);
  assign o_dbg_state = state;

`ifdef LCD_WRITER_BUSYPOLL_EN
  logic [23:0] poll_cnt;   // total cycles spent polling
  logic        flag_q;     // busy flag from the first pulse of the last poll
  logic        poll_active;

  assign poll_active = (state == S_P_SETUP) || (state == S_P_E_HIGH) || (state == S_P_HOLD);
  assign o_done = poll_active &&
                  ((poll_cnt == L_XL) ||
                   ((state == S_P_HOLD) && phase_end && last_pulse && !flag_q));
`else
  logic unused_lcd;
  assign unused_lcd = ^i_lcd_data;
  assign o_done = (state == S_EXEC) && phase_end;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      byte_q      <= '0;
      second_q    <= 1'b0;
      o_r_RW      <= 1'b0;
      o_r_RS      <= 1'b0;
      o_r_E       <= 1'b0;
      o_r_data    <= '0;
      o_r_data_oe <= 1'b1;
`ifdef LCD_WRITER_BUSYPOLL_EN
      poll_cnt    <= '0;
      flag_q      <= 1'b0;
`endif
    end else begin
      cnt <= cnt + 24'd1;
`ifdef LCD_WRITER_BUSYPOLL_EN
      if (poll_active) poll_cnt <= poll_cnt + 24'd1;
`endif
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (i_cs) begin
            state    <= S_SETUP;
            byte_q   <= i_data;
            second_q <= 1'b0;
            o_r_RS   <= i_RS;
            o_r_data <= hi_part;
          end
        end
        S_SETUP: if (phase_end) begin
          state <= S_E_HIGH;
          cnt   <= '0;
          o_r_E <= 1'b1;
        end
        S_E_HIGH: if (phase_end) begin
          state <= S_HOLD;
          cnt   <= '0;
          o_r_E <= 1'b0;
        end
        S_HOLD: if (phase_end) begin
          cnt <= '0;
          if (!last_pulse) begin
            state    <= S_SETUP;
            second_q <= 1'b1;
            o_r_data <= lo_part;
          end else begin
`ifdef LCD_WRITER_BUSYPOLL_EN
            state       <= S_P_SETUP;
            second_q    <= 1'b0;
            poll_cnt    <= '0;
            o_r_RS      <= 1'b0;
            o_r_RW      <= 1'b1;
            o_r_data_oe <= 1'b0;
`else
            state <= S_EXEC;
`endif
          end
        end
        S_EXEC: if (phase_end) begin
          state <= S_IDLE;
          cnt   <= '0;
        end
`ifdef LCD_WRITER_BUSYPOLL_EN
        S_P_SETUP: if (phase_end) begin
          state <= S_P_E_HIGH;
          cnt   <= '0;
          o_r_E <= 1'b1;
        end
        S_P_E_HIGH: if (phase_end) begin
          state <= S_P_HOLD;
          cnt   <= '0;
          o_r_E <= 1'b0;
          // In 4-bit mode the second pulse only completes the read cycle.
          if (!second_q) flag_q <= i_lcd_data[P_BUS_WIDTH-1];
        end
        S_P_HOLD: if (phase_end) begin
          state    <= S_P_SETUP;
          cnt      <= '0;
          second_q <= !last_pulse;
        end
`endif
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
`ifdef LCD_WRITER_BUSYPOLL_EN
      // Flag clear or timeout: finish and hand the bus back to write mode.
      if (o_done) begin
        state       <= S_IDLE;
        cnt         <= '0;
        o_r_E       <= 1'b0;
        o_r_RW      <= 1'b0;
        o_r_data_oe <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_writer
//
// Two engines (8-bit and 4-bit bus) with short timing: S=2, E=4, H=2, X=10,
// XL=50. Every transaction is traced cycle by cycle and compared with a model
// derived from the timing rules (pulse count, phase lengths, nibble order,
// long-execution command decode).
// -----------------------------------------------------------------------------
module tb_lcd_bus_writer;

  localparam int S  = 2;
  localparam int E  = 4;
  localparam int H  = 2;
  localparam int X  = 10;
  localparam int XL = 50;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  logic       cs8 = 1'b0, cs4 = 1'b0;
  logic       i_RS = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [7:0] lcd8 = 8'h00;
  logic [3:0] lcd4 = 4'h0;

  logic       busy8, done8, rw8, rs8, e8, oe8;
  logic [7:0] data8;
  logic [2:0] st8;
  logic       busy4, done4, rw4, rs4, e4, oe4;
  logic [3:0] data4;
  logic [2:0] st4;

  lcd_bus_writer #(
    .P_BUS_WIDTH(8), .P_CNT_SETUP(S), .P_CNT_E_HIGH(E), .P_CNT_HOLD(H),
    .P_CNT_EXEC(X), .P_CNT_EXEC_LONG(XL)
  ) u_dut8 (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(cs8), .i_RS(i_RS), .i_data(i_data),
    .i_lcd_data(lcd8), .o_busy(busy8), .o_done(done8), .o_r_RW(rw8), .o_r_RS(rs8),
    .o_r_E(e8), .o_r_data(data8), .o_r_data_oe(oe8), .o_dbg_state(st8)
  );

  lcd_bus_writer #(
    .P_BUS_WIDTH(4), .P_CNT_SETUP(S), .P_CNT_E_HIGH(E), .P_CNT_HOLD(H),
    .P_CNT_EXEC(X), .P_CNT_EXEC_LONG(XL)
  ) u_dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_cs(cs4), .i_RS(i_RS), .i_data(i_data),
    .i_lcd_data(lcd4), .o_busy(busy4), .o_done(done4), .o_r_RW(rw4), .o_r_RS(rs4),
    .o_r_E(e4), .o_r_data(data4), .o_r_data_oe(oe4), .o_dbg_state(st4)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- output access by bus width ----------------
  function automatic logic g_busy(input int sel); return (sel == 8) ? busy8 : busy4; endfunction
  function automatic logic g_done(input int sel); return (sel == 8) ? done8 : done4; endfunction
  function automatic logic g_rw(input int sel);   return (sel == 8) ? rw8 : rw4;     endfunction
  function automatic logic g_rs(input int sel);   return (sel == 8) ? rs8 : rs4;     endfunction
  function automatic logic g_e(input int sel);    return (sel == 8) ? e8 : e4;       endfunction
  function automatic logic g_oe(input int sel);   return (sel == 8) ? oe8 : oe4;     endfunction
  function automatic logic [7:0] g_data(input int sel);
    return (sel == 8) ? data8 : {4'h0, data4};
  endfunction
  // {busy, done, rw, rs, e, oe, data}
  function automatic logic [13:0] g_pins(input int sel);
    return {g_busy(sel), g_done(sel), g_rw(sel), g_rs(sel), g_e(sel), g_oe(sel), g_data(sel)};
  endfunction
  localparam logic [13:0] RESET_PINS = {6'b000001, 8'h00};

  // ---------------- reference model ----------------
  function automatic int model_pulses(input int sel);
    return (sel == 4) ? 2 : 1;
  endfunction

  function automatic int model_len(input int sel, input logic rs, input logic [7:0] d);
    bit lng;
    lng = (rs == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
    return model_pulses(sel) * (S + E + H) + (lng ? XL : X);
  endfunction

  function automatic logic [7:0] model_nib(input int sel, input logic [7:0] d, input int p);
    if (sel == 8) return d;
    return (p == 0) ? {4'h0, d[7:4]} : {4'h0, d[3:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic set_cs(input int sel, input logic v);
    if (sel == 8) cs8 = v; else cs4 = v;
  endtask

  // mode 0: single request; 1: extra i_cs pulses while busy; 2: i_cs held
  task automatic run_txn(input int sel, input logic rs, input logic [7:0] d,
                         input int mode, input int tbl_len);
    int exp_len, len, len2, done_n, done_at, ehi, bad_pins, np, late_busy;
    logic prev_e;
    int rise_at[$];
    int e_len[$];
    logic [7:0] rise_dat[$];
    logic rise_rs[$];
    exp_len = model_len(sel, rs, d);
    np = model_pulses(sel);
    i_RS = rs;
    i_data = d;
    set_cs(sel, 1'b1);
    @(negedge i_clk);
    if (mode != 2) begin
      set_cs(sel, 1'b0);
      i_RS = ~rs;
      i_data = ~d;
    end
    len = 0; done_n = 0; done_at = 0; ehi = 0; bad_pins = 0; prev_e = 1'b0;
    while (g_busy(sel) === 1'b1 && len < 2000) begin
      len++;
      if (len == 1) begin
        check("setup_data", g_data(sel), model_nib(sel, d, 0));
        check("setup_rs", g_rs(sel), rs);
        check("setup_e_low", g_e(sel), 1'b0);
      end
      if (g_rw(sel) !== 1'b0 || g_oe(sel) !== 1'b1) bad_pins++;
      if (g_done(sel) === 1'b1) begin
        done_n++;
        done_at = len;
      end
      if (g_e(sel) === 1'b1) begin
        if (!prev_e) begin
          rise_at.push_back(len);
          rise_dat.push_back(g_data(sel));
          rise_rs.push_back(g_rs(sel));
        end
        ehi++;
      end else if (prev_e) begin
        e_len.push_back(ehi);
        ehi = 0;
      end
      prev_e = g_e(sel);
      if (mode == 1)
        set_cs(sel, (len == 1 || len == S + E + H + 3 || len == exp_len) ? 1'b1 : 1'b0);
      @(negedge i_clk);
    end
    if (mode == 1) set_cs(sel, 1'b0);

    check("busy_len", len, exp_len);
    if (tbl_len > 0) check("busy_len_table", len, tbl_len);
    check("done_count", done_n, 1);
    check("done_on_last_busy", done_at, exp_len);
    check("pulse_count", rise_at.size(), np);
    for (int p = 0; p < np; p++) begin
      if (p < rise_at.size()) begin
        check("e_rise_cycle", rise_at[p], p * (S + E + H) + S + 1);
        check("e_data", rise_dat[p], model_nib(sel, d, p));
        check("e_rs", rise_rs[p], rs);
      end
      if (p < e_len.size()) check("e_width", e_len[p], E);
    end
    check("rw0_oe1_while_busy", bad_pins, 0);
    check("idle_e", g_e(sel), 1'b0);
    check("idle_done", g_done(sel), 1'b0);
    check("idle_rs_held", g_rs(sel), rs);
    check("idle_data_held", g_data(sel), model_nib(sel, d, np - 1));

    if (mode == 1) begin
      late_busy = 0;
      repeat (3) begin
        @(negedge i_clk);
        if (g_busy(sel) !== 1'b0) late_busy++;
      end
      check("ignored_cs_not_queued", late_busy, 0);
    end else if (mode == 2) begin
      @(negedge i_clk);
      check("back_to_back_restart", g_busy(sel), 1'b1);
      set_cs(sel, 1'b0);
      len2 = 0;
      while (g_busy(sel) === 1'b1 && len2 < 2000) begin
        len2++;
        @(negedge i_clk);
      end
      check("second_busy_len", len2, exp_len);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         sel;
    logic       rs;
    logic [7:0] d;
    int         mode;
    int         len;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ndone;
    vecs[0] = '{8, 1'b1, 8'h41, 0, 18};
    vecs[1] = '{4, 1'b1, 8'hA5, 0, 26};
    vecs[2] = '{8, 1'b0, 8'h01, 0, 58};
    vecs[3] = '{8, 1'b0, 8'h38, 0, 18};
    vecs[4] = '{4, 1'b0, 8'h02, 0, 66};
    vecs[5] = '{4, 1'b0, 8'h04, 0, 26};
    vecs[6] = '{8, 1'b0, 8'h03, 1, 58};
    vecs[7] = '{8, 1'b1, 8'h00, 1, 18};
    vecs[8] = '{8, 1'b1, 8'h55, 2, 18};
    vecs[9] = '{4, 1'b0, 8'h01, 2, 66};

    // reset state
    @(negedge i_clk);
    check("reset_pins8", g_pins(8), RESET_PINS);
    check("reset_pins4", g_pins(4), RESET_PINS);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("post_reset_pins8", g_pins(8), RESET_PINS);

    foreach (vecs[i]) run_txn(vecs[i].sel, vecs[i].rs, vecs[i].d, vecs[i].mode, vecs[i].len);

    // reset in the middle of the E pulse
    i_RS = 1'b1;
    i_data = 8'hFF;
    set_cs(8, 1'b1);
    set_cs(4, 1'b1);
    @(negedge i_clk);
    set_cs(8, 1'b0);
    set_cs(4, 1'b0);
    repeat (S) @(negedge i_clk);
    check("pre_reset_e_high", e8, 1'b1);
    #2 i_reset = 1'b1;
    #1;
    check("async_reset_pins8", g_pins(8), RESET_PINS);
    check("async_reset_pins4", g_pins(4), RESET_PINS);
    ndone = 0;
    repeat (3) begin
      @(negedge i_clk);
      if (done8 !== 1'b0 || done4 !== 1'b0) ndone++;
    end
    check("no_done_in_reset", ndone, 0);
    i_reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) ndone++;
    end
    check("dropped_txn_stays_idle", ndone, 0);
    run_txn(8, 1'b1, 8'h41, 0, 18);
    run_txn(4, 1'b1, 8'hA5, 0, 26);

    // random transactions, biased towards the clear/home corner
    for (int k = 0; k < 24; k++) begin
      int         sel;
      logic       rs;
      logic [7:0] d;
      sel = ($urandom_range(0, 1) == 0) ? 8 : 4;
      rs = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      run_txn(sel, rs, d, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
